// File: rtl/kahn_scheduler_pkg.sv
// Shared types for the Kahn topological-sort scheduler.
// Node width, counter width and FSM state encoding.
package topo_pkg;
   localparam int MAX_NODES  = 1024;
   localparam int NODE_WIDTH = $clog2(MAX_NODES);

   typedef logic [NODE_WIDTH-1:0] node_t;
   typedef logic [NODE_WIDTH:0]   cnt_t;

   typedef enum logic [2:0] {
      IDLE,
      SWEEP,
      POP,
      EMIT,
      QUERY,
      REPLY,
      CHECK,
      DONE
   } kahn_state_t;
endpackage

// File: rtl/kahn_scheduler_if.sv
// Control, indegree-table, successor and sorted-output signals
// of the Kahn scheduler; master is the scheduler side.
interface kahn_scheduler_if;
   import topo_pkg::*;

   logic  start;
   node_t last_node;
   node_t indeg_node;
   logic  indeg_dec;
   node_t indeg_degree;
   logic  query_valid;
   logic  query_ready;
   node_t query_data;
   logic  reply_valid;
   logic  reply_ready;
   logic  reply_last;
   logic  reply_none;
   node_t reply_data;
   logic  sorted_valid;
   logic  sorted_ready;
   node_t sorted_node;
   logic  done;
   logic  cycle_err;

   modport master (
      input  start, last_node, indeg_degree,
      input  query_ready,
      input  reply_valid, reply_last,
      input  reply_none, reply_data,
      input  sorted_ready,
      output indeg_node, indeg_dec,
      output query_valid, query_data,
      output reply_ready,
      output sorted_valid, sorted_node,
      output done, cycle_err
   );

   modport slave (
      output start, last_node, indeg_degree,
      output query_ready,
      output reply_valid, reply_last,
      output reply_none, reply_data,
      output sorted_ready,
      input  indeg_node, indeg_dec,
      input  query_valid, query_data,
      input  reply_ready,
      input  sorted_valid, sorted_node,
      input  done, cycle_err
   );
endinterface

// File: rtl/kahn_scheduler_node_fifo.sv
// Synchronous FIFO of node indices, MAX_NODES deep.
// Pushes into a full FIFO and pops from an empty one are ignored.
module node_fifo
   import topo_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  node_t push_data,
   input  logic  pop,
   output node_t head,
   output logic  empty,
   output logic  full,
   output cnt_t  count
);
   node_t mem [MAX_NODES];
   node_t wr_ptr;
   node_t rd_ptr;

   logic do_push;
   logic do_pop;

   assign empty   = (count == '0);
   assign full    = (count == cnt_t'(MAX_NODES));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + cnt_t'(1);
            2'b01:   count <= count - cnt_t'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/kahn_scheduler.sv
// Kahn topological-sort sequencer: sweep, pop, emit, query, decrement.
// Define KAHN_SCHED_STATS_EN for edge and FIFO high-water counters.
module kahn_scheduler
   import topo_pkg::*;
(
   input  logic clk,
   input  logic rst,
   kahn_scheduler_if.master bus
`ifdef KAHN_SCHED_STATS_EN
   ,
   output cnt_t stat_edges,
   output cnt_t stat_max_occ
`endif
);
   kahn_state_t state;
   node_t last_q;
   cnt_t  s_cnt;
   node_t idx_q;
   cnt_t  emit_cnt;
   node_t lat_node;
   logic  lat_last;
   logic  dropped;

   logic  push;
   node_t push_data;
   logic  pop;
   node_t head;
   logic  empty;
   logic  full;
   logic  rep_fire;
   logic  zero_deg;
   cnt_t  n_total;

   assign n_total  = cnt_t'(last_q) + cnt_t'(1);
   assign zero_deg = (bus.indeg_degree == '0);
   assign rep_fire = (state == REPLY) && bus.reply_valid
                     && !bus.reply_none;

   // Decrement address goes out with the beat so CHECK sees the result.
   assign bus.indeg_node = rep_fire ? bus.reply_data : idx_q;
   assign bus.indeg_dec  = rep_fire;

   assign push = zero_deg
                 && ((state == CHECK)
                     || ((state == SWEEP) && (s_cnt != '0)));
   assign push_data = (state == CHECK) ? lat_node
                      : node_t'(s_cnt - cnt_t'(1));
   assign pop = (state == POP) && !empty;

`ifdef KAHN_SCHED_STATS_EN
   cnt_t occ;
`endif

   node_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .empty     (empty),
      .full      (full),
`ifdef KAHN_SCHED_STATS_EN
      .count     (occ)
`else
      .count     ()
`endif
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         last_q           <= '0;
         s_cnt            <= '0;
         idx_q            <= '0;
         emit_cnt         <= '0;
         lat_node         <= '0;
         lat_last         <= 1'b0;
         dropped          <= 1'b0;
         bus.query_valid  <= 1'b0;
         bus.query_data   <= '0;
         bus.reply_ready  <= 1'b0;
         bus.sorted_valid <= 1'b0;
         bus.sorted_node  <= '0;
         bus.done         <= 1'b0;
         bus.cycle_err    <= 1'b0;
      end else begin
         if (push && full) dropped <= 1'b1;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  last_q        <= bus.last_node;
                  s_cnt         <= '0;
                  idx_q         <= '0;
                  emit_cnt      <= '0;
                  dropped       <= 1'b0;
                  bus.done      <= 1'b0;
                  bus.cycle_err <= 1'b0;
                  state         <= SWEEP;
               end
            end
            SWEEP: begin
               if (s_cnt == n_total) begin
                  state <= POP;
               end else begin
                  s_cnt <= s_cnt + cnt_t'(1);
                  idx_q <= (s_cnt < cnt_t'(last_q))
                           ? node_t'(s_cnt + cnt_t'(1)) : '0;
               end
            end
            POP: begin
               if (empty) begin
                  bus.done      <= 1'b1;
                  bus.cycle_err <= (emit_cnt != n_total) | dropped;
                  state         <= DONE;
               end else begin
                  bus.sorted_valid <= 1'b1;
                  bus.sorted_node  <= head;
                  state            <= EMIT;
               end
            end
            EMIT: begin
               if (bus.sorted_ready) begin
                  bus.sorted_valid <= 1'b0;
                  emit_cnt         <= emit_cnt + cnt_t'(1);
                  bus.query_valid  <= 1'b1;
                  bus.query_data   <= bus.sorted_node;
                  state            <= QUERY;
               end
            end
            QUERY: begin
               if (bus.query_ready) begin
                  bus.query_valid <= 1'b0;
                  bus.reply_ready <= 1'b1;
                  state           <= REPLY;
               end
            end
            REPLY: begin
               if (bus.reply_valid) begin
                  bus.reply_ready <= 1'b0;
                  if (bus.reply_none) begin
                     state <= POP;
                  end else begin
                     lat_node <= bus.reply_data;
                     lat_last <= bus.reply_last;
                     state    <= CHECK;
                  end
               end
            end
            CHECK: begin
               if (lat_last) begin
                  state <= POP;
               end else begin
                  bus.reply_ready <= 1'b1;
                  state           <= REPLY;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef KAHN_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || ((state == IDLE) && bus.start)) begin
         stat_edges   <= '0;
         stat_max_occ <= '0;
      end else begin
         if (rep_fire && (stat_edges != '1))
            stat_edges <= stat_edges + cnt_t'(1);
         if (occ > stat_max_occ)
            stat_max_occ <= occ;
      end
   end
`endif
endmodule

// File: tb/tb_kahn_scheduler.sv
// Scoreboard bench for kahn_scheduler with indegree-table and
// successor-stream models; sorted output checked by a monitor.
module tb_kahn_scheduler;
   import topo_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   kahn_scheduler_if bus ();

`ifdef KAHN_SCHED_STATS_EN
   cnt_t stat_edges;
   cnt_t stat_max_occ;
`endif

   kahn_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef KAHN_SCHED_STATS_EN
      ,
      .stat_edges   (stat_edges),
      .stat_max_occ (stat_max_occ)
`endif
   );

   int    succ  [MAX_NODES][4];
   int    nsucc [MAX_NODES];
   node_t tbl   [MAX_NODES];
   node_t pend;
   int    exp_q [$];
   int    passed = 0;
   int    total  = 0;
   int    emitted = 0;
   bit    stall_en = 1'b0;
   int    sr_hold = 0;
   int    qr_hold = 0;
   bit    rbusy = 1'b0;
   int    rnode = 0;
   int    rk = 0;

   bit    p_sv, p_sr, p_qv, p_qr, p_rv, p_rr, p_rl;
   node_t p_sn, p_qd;

   task automatic check(input bit ok, input string name,
                        input int act, input int req);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %0d, expected %0d",
                    name, act, req);
   endtask

   task automatic clear_graph();
      for (int i = 0; i < MAX_NODES; i++) begin
         nsucc[i] = 0;
         tbl[i]   = '0;
      end
   endtask

   task automatic add_edge(input int a, input int b);
      succ[a][nsucc[a]] = b;
      nsucc[a]++;
      tbl[b] = tbl[b] + 1'b1;
   endtask

   task automatic diamond();
      clear_graph();
      add_edge(0, 1);
      add_edge(0, 2);
      add_edge(1, 3);
      add_edge(2, 3);
      exp_q = '{0, 1, 2, 3};
   endtask

   // Responders and monitor all act on the falling edge; the p_*
   // copies hold what was stable across the preceding rising edge.
   initial begin
      int e;
      forever begin
         @(negedge clk);
         if (rst) begin
            rbusy = 1'b0;
            {p_sv, p_sr, p_qv, p_qr, p_rv, p_rr, p_rl} = '0;
            bus.reply_valid  = 1'b0;
            bus.reply_last   = 1'b0;
            bus.reply_none   = 1'b0;
            bus.reply_data   = '0;
            bus.sorted_ready = 1'b0;
            bus.query_ready  = 1'b0;
            sr_hold = 0;
            qr_hold = 0;
         end else begin
            if (p_sv && p_sr) begin
               emitted++;
               if (exp_q.size() == 0) begin
                  check(1'b0, "unexpected_node", p_sn, -1);
               end else begin
                  e = exp_q.pop_front();
                  check(p_sn == node_t'(e), "sorted_node", p_sn, e);
               end
            end else if (p_sv) begin
               check(bus.sorted_valid && bus.sorted_node == p_sn,
                     "sorted_hold", bus.sorted_node, p_sn);
            end
            if (p_rv && p_rr) begin
               if (p_rl) rbusy = 1'b0;
               else rk++;
            end
            if (p_qv && p_qr) begin
               rbusy = 1'b1;
               rnode = int'(p_qd);
               rk    = 0;
            end else if (p_qv) begin
               check(bus.query_valid && bus.query_data == p_qd,
                     "query_hold", bus.query_data, p_qd);
            end
            if (rbusy) begin
               bus.reply_valid = 1'b1;
               if (nsucc[rnode] == 0) begin
                  bus.reply_none = 1'b1;
                  bus.reply_last = 1'b1;
                  bus.reply_data = '0;
               end else begin
                  bus.reply_none = 1'b0;
                  bus.reply_last = (rk == nsucc[rnode] - 1);
                  bus.reply_data = node_t'(succ[rnode][rk]);
               end
            end else begin
               bus.reply_valid = 1'b0;
               bus.reply_none  = 1'b0;
               bus.reply_last  = 1'b0;
               bus.reply_data  = '0;
            end
            if (stall_en) begin
               if (sr_hold > 0) sr_hold--;
               else if ($urandom_range(0, 5) == 0) sr_hold = 5;
               if (qr_hold > 0) qr_hold--;
               else if ($urandom_range(0, 5) == 0) qr_hold = 5;
            end else begin
               sr_hold = 0;
               qr_hold = 0;
            end
            bus.sorted_ready = (sr_hold == 0);
            bus.query_ready  = (qr_hold == 0);
            p_sv = bus.sorted_valid;
            p_sr = bus.sorted_ready;
            p_sn = bus.sorted_node;
            p_qv = bus.query_valid;
            p_qr = bus.query_ready;
            p_qd = bus.query_data;
            p_rv = bus.reply_valid;
            p_rr = bus.reply_ready;
            p_rl = bus.reply_last;
         end
         #1;
         if (!rst) begin
            bus.indeg_degree = pend;
            if (bus.indeg_dec)
               tbl[bus.indeg_node] = tbl[bus.indeg_node] - 1'b1;
            pend = tbl[bus.indeg_node];
         end
      end
   end

   task automatic run(input int last, input bit exp_cyc,
                      input int exp_emit, input string tag);
      emitted = 0;
      bus.last_node = node_t'(last);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check(!bus.done, {tag, "_done_clr"}, bus.done, 0);
      for (int c = 0; c < 20000 && !bus.done; c++)
         @(negedge clk);
      check(bus.done, {tag, "_done"}, bus.done, 1);
      check(bus.cycle_err == exp_cyc, {tag, "_cycle_err"},
            bus.cycle_err, exp_cyc);
      check(emitted == exp_emit, {tag, "_emitted"},
            emitted, exp_emit);
      check(exp_q.size() == 0, {tag, "_missing"},
            exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
   endtask

   function automatic int out_word();
      return int'({bus.indeg_node, bus.indeg_dec,
                   bus.query_valid, bus.query_data,
                   bus.reply_ready, bus.sorted_valid,
                   bus.sorted_node, bus.done, bus.cycle_err});
   endfunction

   initial begin
      bus.start        = 1'b0;
      bus.last_node    = '0;
      bus.indeg_degree = '0;
      pend             = '0;
      repeat (3) @(negedge clk);
      check(out_word() == 0, "reset_outputs", out_word(), 0);
      rst = 1'b0;
      @(negedge clk);

      clear_graph();
      add_edge(0, 1);
      add_edge(1, 2);
      exp_q = '{0, 1, 2};
      run(2, 1'b0, 3, "chain");

      diamond();
      run(3, 1'b0, 4, "diamond");
`ifdef KAHN_SCHED_STATS_EN
      check(stat_edges == cnt_t'(4), "stat_edges", stat_edges, 4);
      check(stat_max_occ == cnt_t'(2), "stat_max_occ",
            stat_max_occ, 2);
`endif

      clear_graph();
      add_edge(0, 1);
      add_edge(1, 2);
      add_edge(2, 0);
      exp_q = '{3};
      run(3, 1'b1, 1, "cycle");

      stall_en = 1'b1;
      diamond();
      run(3, 1'b0, 4, "stall");
      clear_graph();
      for (int i = 0; i < 5; i++) add_edge(i, i + 1);
      exp_q = '{0, 1, 2, 3, 4, 5};
      run(5, 1'b0, 6, "stall_chain");
      stall_en = 1'b0;

      diamond();
      bus.last_node = node_t'(3);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c < 500 && !bus.reply_ready; c++)
         @(negedge clk);
      check(bus.reply_ready, "reach_reply", bus.reply_ready, 1);
      rst = 1'b1;
      @(negedge clk);
      check(out_word() == 0, "rst_outputs_1", out_word(), 0);
      @(negedge clk);
      check(out_word() == 0, "rst_outputs_2", out_word(), 0);
      exp_q.delete();
      rst = 1'b0;
      @(negedge clk);
      diamond();
      run(3, 1'b0, 4, "after_rst");

      clear_graph();
      for (int i = 0; i < MAX_NODES; i++) exp_q.push_back(i);
      run(MAX_NODES - 1, 1'b0, MAX_NODES, "full");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
